uart_tx_frame: RTL
==================

# uart_tx_frame

Parametrised UART transmit framer: accepts a parallel word over a valid/ready handshake and serialises it onto `tx` as start bit, LSB-first data, optional parity and stop bit(s), each held for a programmable number of clock cycles. It is the transmitter datapath's serialiser stage, sitting between the TX holding logic and the line pin. It generalises the fixed 8-bit, one-bit-per-clock shifter with configurable width, baud timing, framing and flow control.

## Interface
- `DATA_W`, 8, data bits per frame (5–9)
- `CLKS_PER_BIT`, 16, clock cycles per line bit (≥2)
- `STOP_BITS`, 1, stop bits per frame (1 or 2)
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `data_in`  in  DATA_W  word to transmit; sampled only on handshake
- `valid_in`  in  1  word available
- `ready_out`  out  1  framer idle; handshake completes when `valid_in && ready_out` at a rising edge
- `tx`  out  1  serial line, registered, idles high
- `busy`  out  1  frame in progress (START through last STOP)
- `done`  out  1  one-cycle pulse after the final stop-bit period ends

## Operation
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: `tx`=1, `ready_out`=1, `busy`=0. On handshake: load `data_in` into shift register, clear bit counter and baud counter, go START.
- Baud counter counts 0..CLKS_PER_BIT-1; the bit period ends when count = CLKS_PER_BIT-1, then the counter wraps to 0 and the state/bit advances.
- START: `tx`=0 for one bit period, then DATA.
- DATA: `tx`=shift[0]; at end of each bit period shift right by one and increment bit index; after bit DATA_W-1 go PARITY (if compiled in) else STOP.
- STOP: `tx`=1 for STOP_BITS bit periods; at the end go IDLE and assert `done` for exactly one cycle.
- `valid_in` while not ready is ignored; no queuing. `data_in` changes after the handshake have no effect on the frame in flight.
- Back-to-back: a handshake is accepted in the same cycle `done` is high (the state is IDLE).
- Bit-index counter width is $clog2(DATA_W); the baud counter width is $clog2(CLKS_PER_BIT).

## Timing
- Reset values: `tx`=1, `ready_out`=1, `busy`=0, `done`=0; state IDLE, counters 0, shift register 0.
- Handshake at edge k: `tx`=0 and `busy`=1 from edge k+1 onward.
- Frame length F = (1 + DATA_W + P + STOP_BITS) × CLKS_PER_BIT cycles, where P=1 with the parity macro and 0 without it. `done` is high in cycle k+F+1. `ready_out` is high in that same cycle.
- Back-to-back frames: inter-frame gap is exactly 1 extra idle-high cycle.
- `rst` mid-frame: at the next edge, the frame is aborted, `tx`=1, `done` is not pulsed, and the state is IDLE. A handshake in the reset cycle is dropped.
- `rst` has priority over the handshake.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state between DATA and STOP drives the even-parity bit (XOR of all DATA_W bits, computed at load and held) for one bit period.
- Macro undefined: no PARITY state and no parity register. DATA goes directly to STOP. P=0 in all timing.

## Structure
- Shared package `uart_pkg`: state enum (IDLE, START, DATA, PARITY, STOP), `UART_IDLE_LEVEL`=1'b1, `UART_START_LEVEL`=1'b0.
- One sub-module `uart_baud_tick`, parametrised by CLKS_PER_BIT. Inputs: `clk`, `rst`, `clear`. It emits a one-cycle `tick` on the last cycle of each bit period. The FSM advances only on `tick`.

## Test plan
- Reset hold then release, no valid: `tx`=1, `ready_out`=1, `busy`=0, `done`=0 for 100 cycles.
- DATA_W=8, CLKS_PER_BIT=4, no parity, send 0xA5: `tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. `done` pulses 41 cycles after the handshake edge.
- Parity build, send 0xA5 → parity bit 0. Send 0x07 → parity bit 1. Each frame is 44 cycles.
- Hold `valid_in`=1 with 0x01 then 0x80: two frames with exactly one idle-high cycle between the last stop bit and the second start bit.
- Assert `rst` during data bit 3 of 0xFF: next cycle `tx`=1, `busy`=0, `ready_out`=1, and no `done`.
- STOP_BITS=2, send 0x00: `tx` high for 8 cycles after the data bits before `done`. A `valid_in` pulse mid-frame is ignored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit framer: FSM state encoding and
// the line levels used for idle and start conditions.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_frame_baud_tick.sv
// Bit-period timer for the UART framer. Counts 0..CLKS_PER_BIT-1 and raises
// tick on the last cycle of each period. clear restarts the period so a new
// frame's start bit gets a full bit time.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST_COUNT);

    // Next count: wrap at the end of a period, restart on clear
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: takes a word over valid/ready and shifts it out on tx
// as start bit, LSB-first data, optional even parity and STOP_BITS stop bits.
// Optional feature macro: UART_TX_PARITY_EN adds the parity bit.
import uart_pkg::*;

module uart_tx_frame #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic handshake;
    logic tick;

    assign ready_out = (state_q == ST_IDLE);
    assign busy      = ~ready_out;
    assign handshake = valid_in && ready_out;
    assign tx        = tx_q;
    assign done      = done_q;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(handshake),
        .tick (tick)
    );

    // Framing FSM: tx_d is the level for the bit period that starts at the
    // next edge, so the registered line changes together with the state
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d = UART_IDLE_LEVEL;
                if (handshake) begin
                    shift_d  = data_in;
                    bit_d    = '0;
                    tx_d     = UART_START_LEVEL;
                    state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^data_in;
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = UART_IDLE_LEVEL;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                        tx_d  = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                    tx_d    = UART_IDLE_LEVEL;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (bit_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        tx_d    = UART_IDLE_LEVEL;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = UART_IDLE_LEVEL;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame without done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            tx_q     <= UART_IDLE_LEVEL;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
